// File: rtl/sdram_bram_responder.sv
// SDR SDRAM command responder backed by a 16-bit block RAM.
// Ports: clk, rst_n (sync, active-low); addr, bank_addr, clken, cs_n,
//   ras_n, cas_n, we_n, dqm, dq_in (controller side); dq_out, dq_oe,
//   proto_err (sticky), ref_count (saturating REF count).
module sdram_bram_responder #(
  parameter int ROW_WIDTH      = 12,
  parameter int COL_WIDTH      = 8,
  parameter int BANK_WIDTH     = 2,
  parameter int SDRADDR_WIDTH  = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SDRADDR_WIDTH-1:0] addr,
  input  logic [BANK_WIDTH-1:0]    bank_addr,
  input  logic                     clken,
  input  logic                     cs_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     we_n,
  input  logic [1:0]               dqm,
  input  logic [15:0]              dq_in,
  output logic [15:0]              dq_out,
  output logic                     dq_oe,
  output logic                     proto_err,
  output logic [15:0]              ref_count
);

  localparam int NB    = 1 << BANK_WIDTH;
  localparam int FULLW = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef logic [MEM_ADDR_WIDTH-1:0] maddr_t;
  typedef logic [COL_WIDTH-1:0]      col_t;
  typedef logic [ROW_WIDTH-1:0]      row_t;
  typedef logic [BANK_WIDTH-1:0]     bank_t;

  // Column within the BL-aligned block, wrapping inside it.
  function automatic col_t wrap_col(input col_t c, input logic [3:0] bl,
                                    input logic [3:0] off);
    col_t m;
    m = COL_WIDTH'(bl) - COL_WIDTH'(1);
    return (c & ~m) | ((c + COL_WIDTH'(off)) & m);
  endfunction

  // {bank,row,col} truncated: higher address bits alias.
  function automatic maddr_t mem_idx(input bank_t b, input row_t r,
                                     input col_t c);
    logic [FULLW-1:0] f;
    f = {b, r, c};
    return f[MEM_ADDR_WIDTH-1:0];
  endfunction

  logic [15:0] mem [DEPTH];

  logic [NB-1:0] open_q, open_d;
  row_t          row_q [NB];
  row_t          row_d [NB];
  logic [3:0]    bl_q, bl_d;
  logic [1:0]    cl_q, cl_d;
  logic          wm_q, wm_d;

  logic          rd_act_q, rd_act_d;
  logic [3:0]    rd_cyc_q, rd_cyc_d;
  bank_t         rd_bank_q, rd_bank_d;
  row_t          rd_row_q, rd_row_d;
  col_t          rd_col_q, rd_col_d;
  logic [3:0]    rd_bl_q, rd_bl_d;
  logic [1:0]    rd_cl_q, rd_cl_d;
  logic          rd_ap_q, rd_ap_d;

  logic          wr_act_q, wr_act_d;
  logic [3:0]    wr_idx_q, wr_idx_d;
  bank_t         wr_bank_q, wr_bank_d;
  row_t          wr_row_q, wr_row_d;
  col_t          wr_col_q, wr_col_d;
  logic [3:0]    wr_bl_q, wr_bl_d;
  logic          wr_ap_q, wr_ap_d;

  logic          oe_q, oe_d;
  logic [15:0]   dout_q, dout_d;
  logic          perr_q, perr_d;
  logic [15:0]   refc_q, refc_d;

  logic          mem_we;
  maddr_t        mem_wa;
  maddr_t        rd_addr;
  logic [3:0]    rd_end, rd_off;
  logic          cmd_en, hit, new_rw, rd_valid;
  logic [2:0]    cmd;
  logic          unused_addr;

  assign unused_addr = ^addr;
  assign cmd_en = clken & ~cs_n;
  assign cmd    = {ras_n, cas_n, we_n};
  assign hit    = open_q[bank_addr];
  // A legal READ/WRITE cuts off whatever burst is running.
  assign new_rw = cmd_en & hit & ((cmd == 3'b101) | (cmd == 3'b100));

  always_comb begin
    open_d    = open_q;
    row_d     = row_q;
    bl_d      = bl_q;
    cl_d      = cl_q;
    wm_d      = wm_q;
    rd_act_d  = rd_act_q;
    rd_cyc_d  = rd_cyc_q;
    rd_bank_d = rd_bank_q;
    rd_row_d  = rd_row_q;
    rd_col_d  = rd_col_q;
    rd_bl_d   = rd_bl_q;
    rd_cl_d   = rd_cl_q;
    rd_ap_d   = rd_ap_q;
    wr_act_d  = wr_act_q;
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_bl_d   = wr_bl_q;
    wr_ap_d   = wr_ap_q;
    perr_d    = perr_q;
    refc_d    = refc_q;
    mem_we    = 1'b0;
    mem_wa    = '0;

    // rd_cyc counts edges since the READ; words land on CL..CL+BL-1.
    rd_end   = {2'b00, rd_cl_q} + rd_bl_q - 4'd1;
    rd_off   = rd_cyc_q - {2'b00, rd_cl_q};
    rd_addr  = mem_idx(rd_bank_q, rd_row_q,
                       wrap_col(rd_col_q, rd_bl_q, rd_off));
    rd_valid = rd_act_q & ~new_rw &
               (rd_cyc_q >= {2'b00, rd_cl_q}) & (rd_cyc_q <= rd_end);
    oe_d     = rd_valid;
    dout_d   = rd_valid ? mem[rd_addr] : 16'h0000;

    if (rd_act_q && !new_rw) begin
      rd_cyc_d = rd_cyc_q + 4'd1;
      if (rd_cyc_q == rd_end) begin
        rd_act_d = 1'b0;
        if (rd_ap_q) open_d[rd_bank_q] = 1'b0;
      end
    end

    if (wr_act_q && !new_rw) begin
      mem_we   = 1'b1;
      mem_wa   = mem_idx(wr_bank_q, wr_row_q,
                         wrap_col(wr_col_q, wr_bl_q, wr_idx_q));
      wr_idx_d = wr_idx_q + 4'd1;
      if (wr_idx_q == wr_bl_q - 4'd1) begin
        wr_act_d = 1'b0;
        if (wr_ap_q) open_d[wr_bank_q] = 1'b0;
      end
    end

    if (cmd_en) begin
      case (cmd)
        3'b011: begin
          if (hit) perr_d = 1'b1;
          else begin
            open_d[bank_addr] = 1'b1;
            row_d[bank_addr]  = addr[ROW_WIDTH-1:0];
          end
        end
        3'b101: begin
          if (!hit) perr_d = 1'b1;
          else begin
            wr_act_d  = 1'b0;
            rd_act_d  = 1'b1;
            rd_cyc_d  = 4'd1;
            rd_bank_d = bank_addr;
            rd_row_d  = row_q[bank_addr];
            rd_col_d  = addr[COL_WIDTH-1:0];
            rd_bl_d   = bl_q;
            rd_cl_d   = cl_q;
            rd_ap_d   = addr[10];
          end
        end
        3'b100: begin
          if (!hit) perr_d = 1'b1;
          else begin
            rd_act_d  = 1'b0;
            mem_we    = 1'b1;
            mem_wa    = mem_idx(bank_addr, row_q[bank_addr],
                                addr[COL_WIDTH-1:0]);
            wr_bank_d = bank_addr;
            wr_row_d  = row_q[bank_addr];
            wr_col_d  = addr[COL_WIDTH-1:0];
            wr_bl_d   = wm_q ? 4'd1 : bl_q;
            wr_ap_d   = addr[10];
            wr_idx_d  = 4'd1;
            if (wm_q || bl_q == 4'd1) begin
              wr_act_d = 1'b0;
              if (addr[10]) open_d[bank_addr] = 1'b0;
            end else begin
              wr_act_d = 1'b1;
            end
          end
        end
        3'b010: begin
          if (addr[10]) open_d = '0;
          else open_d[bank_addr] = 1'b0;
        end
        3'b001: begin
          if (|open_q) perr_d = 1'b1;
          if (refc_q != 16'hFFFF) refc_d = refc_q + 16'd1;
        end
        3'b000: begin
          case (addr[2:0])
            3'b001:  bl_d = 4'd2;
            3'b010:  bl_d = 4'd4;
            3'b011:  bl_d = 4'd8;
            default: bl_d = 4'd1;
          endcase
          cl_d = (addr[6:4] == 3'b011) ? 2'd3 : 2'd2;
          wm_d = addr[9];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      open_q    <= '0;
      bl_q      <= 4'd1;
      cl_q      <= 2'd2;
      wm_q      <= 1'b1;
      rd_act_q  <= 1'b0;
      rd_cyc_q  <= '0;
      rd_bank_q <= '0;
      rd_row_q  <= '0;
      rd_col_q  <= '0;
      rd_bl_q   <= 4'd1;
      rd_cl_q   <= 2'd2;
      rd_ap_q   <= 1'b0;
      wr_act_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_bank_q <= '0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_bl_q   <= 4'd1;
      wr_ap_q   <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= '0;
      perr_q    <= 1'b0;
      refc_q    <= '0;
    end else begin
      open_q    <= open_d;
      bl_q      <= bl_d;
      cl_q      <= cl_d;
      wm_q      <= wm_d;
      rd_act_q  <= rd_act_d;
      rd_cyc_q  <= rd_cyc_d;
      rd_bank_q <= rd_bank_d;
      rd_row_q  <= rd_row_d;
      rd_col_q  <= rd_col_d;
      rd_bl_q   <= rd_bl_d;
      rd_cl_q   <= rd_cl_d;
      rd_ap_q   <= rd_ap_d;
      wr_act_q  <= wr_act_d;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_bl_q   <= wr_bl_d;
      wr_ap_q   <= wr_ap_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      perr_q    <= perr_d;
      refc_q    <= refc_d;
    end
  end

  // Open rows are only meaningful while the bank is open.
  always_ff @(posedge clk) begin
    row_q <= row_d;
  end

  // Storage has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      if (!dqm[1]) mem[mem_wa][15:8] <= dq_in[15:8];
      if (!dqm[0]) mem[mem_wa][7:0]  <= dq_in[7:0];
    end
  end

  assign dq_oe     = oe_q;
  assign dq_out    = dout_q;
  assign proto_err = perr_q;
  assign ref_count = refc_q;

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Directed bench for sdram_bram_responder.
// Each task drives one scenario and checks outputs inline.
module tb_sdram_bram_responder;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_MRS = 3'b000;

  logic        clk;
  logic        rst_n;
  logic [11:0] addr;
  logic [1:0]  bank_addr;
  logic        clken, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  dqm;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        proto_err;
  logic [15:0] ref_count;

  int checks = 0;
  int failures = 0;

  sdram_bram_responder dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .bank_addr(bank_addr),
    .clken(clken), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .dqm(dqm), .dq_in(dq_in), .dq_out(dq_out),
    .dq_oe(dq_oe), .proto_err(proto_err), .ref_count(ref_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on the next edge, then return to NOP.
  task automatic cmd(input logic [2:0] c, input logic [1:0] b,
                     input logic [11:0] a, input logic [15:0] d,
                     input logic [1:0] m);
    @(negedge clk);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    bank_addr = b;
    addr = a;
    dq_in = d;
    dqm = m;
    @(posedge clk);
    #1;
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
  endtask

  task automatic nop_data(input logic [15:0] d);
    @(negedge clk);
    dq_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (dq_oe !== 1'b0) begin
      failures++;
      $display("FAIL reset_oe got=%b exp=0", dq_oe);
    end
    checks++;
    if (dq_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_dout got=%h exp=0000", dq_out);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_perr got=%b exp=0", proto_err);
    end
    checks++;
    if (ref_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_refc got=%0d exp=0", ref_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ref();
    repeat (3) cmd(C_REF, 2'd0, 12'h000, 16'h0, 2'b00);
    checks++;
    if (ref_count !== 16'd3) begin
      failures++;
      $display("FAIL ref_count got=%0d exp=3", ref_count);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL ref_perr got=%b exp=0", proto_err);
    end
  endtask

  task automatic test_basic_read();
    logic [15:0] exp_d [4];
    logic        exp_oe;
    exp_d = '{16'hA5A5, 16'h1111, 16'h2222, 16'h3333};
    cmd(C_MRS, 2'd0, 12'h222, 16'h0, 2'b00);
    cmd(C_ACT, 2'd1, 12'h005, 16'h0, 2'b00);
    cmd(C_WR, 2'd1, 12'h010, 16'hA5A5, 2'b00);
    cmd(C_WR, 2'd1, 12'h011, 16'h1111, 2'b00);
    cmd(C_WR, 2'd1, 12'h012, 16'h2222, 2'b00);
    cmd(C_WR, 2'd1, 12'h013, 16'h3333, 2'b00);
    cmd(C_RD, 2'd1, 12'h410, 16'h0, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_oe = (k >= 2) && (k <= 5);
      checks++;
      if (dq_oe !== exp_oe) begin
        failures++;
        $display("FAIL bl4_oe[%0d] got=%b exp=%b", k, dq_oe, exp_oe);
      end
      checks++;
      if (exp_oe && dq_out !== exp_d[k-2]) begin
        failures++;
        $display("FAIL bl4_data[%0d] got=%h exp=%h", k, dq_out, exp_d[k-2]);
      end else if (!exp_oe && dq_out !== 16'h0) begin
        failures++;
        $display("FAIL bl4_idle[%0d] got=%h exp=0000", k, dq_out);
      end
    end
    // Bank 1 must be closed by auto-precharge, so ACT is legal.
    cmd(C_ACT, 2'd1, 12'h005, 16'h0, 2'b00);
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL autopre_perr got=%b exp=0", proto_err);
    end
  endtask

  task automatic test_mask();
    cmd(C_MRS, 2'd0, 12'h220, 16'h0, 2'b00);
    cmd(C_WR, 2'd1, 12'h020, 16'h1234, 2'b00);
    cmd(C_WR, 2'd1, 12'h020, 16'hABCD, 2'b10);
    cmd(C_RD, 2'd1, 12'h020, 16'h0, 2'b11);
    tick();
    tick();
    checks++;
    if (dq_oe !== 1'b1 || dq_out !== 16'h12CD) begin
      failures++;
      $display("FAIL mask_hi got=%b/%h exp=1/12cd", dq_oe, dq_out);
    end
    tick();
    checks++;
    if (dq_oe !== 1'b0) begin
      failures++;
      $display("FAIL bl1_end got=%b exp=0", dq_oe);
    end
    cmd(C_WR, 2'd1, 12'h020, 16'h5678, 2'b01);
    cmd(C_RD, 2'd1, 12'h020, 16'h0, 2'b00);
    tick();
    tick();
    checks++;
    if (dq_oe !== 1'b1 || dq_out !== 16'h56CD) begin
      failures++;
      $display("FAIL mask_lo got=%b/%h exp=1/56cd", dq_oe, dq_out);
    end
  endtask

  task automatic test_burst_wrap();
    logic        exp_oe;
    logic [15:0] exp_v;
    cmd(C_MRS, 2'd0, 12'h033, 16'h0, 2'b00);
    cmd(C_WR, 2'd1, 12'h000, 16'h1000, 2'b00);
    for (int i = 1; i < 8; i++) nop_data(16'h1000 + 16'(i));
    cmd(C_RD, 2'd1, 12'h006, 16'h0, 2'b00);
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_oe = (k >= 3) && (k <= 10);
      exp_v  = exp_oe ? (16'h1000 | 16'((6 + k - 3) % 8)) : 16'h0;
      checks++;
      if (dq_oe !== exp_oe || dq_out !== exp_v) begin
        failures++;
        $display("FAIL bl8_wrap[%0d] got=%b/%h exp=%b/%h",
                 k, dq_oe, dq_out, exp_oe, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    cmd(C_RD, 2'd1, 12'h006, 16'h0, 2'b00);
    repeat (4) tick();
    checks++;
    if (dq_oe !== 1'b1 || dq_out !== 16'h1007) begin
      failures++;
      $display("FAIL pre_rst got=%b/%h exp=1/1007", dq_oe, dq_out);
    end
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    checks++;
    if (dq_oe !== 1'b0 || dq_out !== 16'h0) begin
      failures++;
      $display("FAIL rst_mid got=%b/%h exp=0/0000", dq_oe, dq_out);
    end
    checks++;
    if (ref_count !== 16'd0) begin
      failures++;
      $display("FAIL rst_refc got=%0d exp=0", ref_count);
    end
    rst_n = 1'b1;
    cmd(C_RD, 2'd1, 12'h010, 16'h0, 2'b00);
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL closed_rd_perr got=%b exp=1", proto_err);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (dq_oe !== 1'b0 || proto_err !== 1'b1) begin
        failures++;
        $display("FAIL closed_rd[%0d] got=%b/%b exp=0/1",
                 k, dq_oe, proto_err);
      end
    end
  endtask

  task automatic test_alias_preserve();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL perr_clear got=%b exp=0", proto_err);
    end
    // Bank 2 row 1 aliases bank 1 row 5 in a 1K-word store.
    cmd(C_ACT, 2'd2, 12'h001, 16'h0, 2'b00);
    cmd(C_RD, 2'd2, 12'h010, 16'h0, 2'b00);
    tick();
    checks++;
    if (dq_oe !== 1'b0) begin
      failures++;
      $display("FAIL cl2_early got=%b exp=0", dq_oe);
    end
    tick();
    checks++;
    if (dq_oe !== 1'b1 || dq_out !== 16'hA5A5) begin
      failures++;
      $display("FAIL alias got=%b/%h exp=1/a5a5", dq_oe, dq_out);
    end
    tick();
    checks++;
    if (dq_oe !== 1'b0) begin
      failures++;
      $display("FAIL alias_end got=%b exp=0", dq_oe);
    end
    cmd(C_ACT, 2'd2, 12'h001, 16'h0, 2'b00);
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL act_open got=%b exp=1", proto_err);
    end
  endtask

  task automatic test_precharge_ref();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cmd(C_ACT, 2'd0, 12'h000, 16'h0, 2'b00);
    cmd(C_ACT, 2'd3, 12'h000, 16'h0, 2'b00);
    cmd(C_PRE, 2'd0, 12'h400, 16'h0, 2'b00);
    cmd(C_REF, 2'd0, 12'h000, 16'h0, 2'b00);
    checks++;
    if (proto_err !== 1'b0 || ref_count !== 16'd1) begin
      failures++;
      $display("FAIL pre_all got=%b/%0d exp=0/1", proto_err, ref_count);
    end
    cmd(C_ACT, 2'd0, 12'h000, 16'h0, 2'b00);
    cmd(C_ACT, 2'd1, 12'h000, 16'h0, 2'b00);
    cmd(C_PRE, 2'd0, 12'h000, 16'h0, 2'b00);
    cmd(C_ACT, 2'd0, 12'h000, 16'h0, 2'b00);
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL pre_one got=%b exp=0", proto_err);
    end
    cmd(C_REF, 2'd0, 12'h000, 16'h0, 2'b00);
    checks++;
    if (proto_err !== 1'b1 || ref_count !== 16'd2) begin
      failures++;
      $display("FAIL ref_open got=%b/%0d exp=1/2", proto_err, ref_count);
    end
    clken = 1'b0;
    cmd(C_REF, 2'd0, 12'h000, 16'h0, 2'b00);
    clken = 1'b1;
    checks++;
    if (ref_count !== 16'd2) begin
      failures++;
      $display("FAIL clken_off got=%0d exp=2", ref_count);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clken = 1'b1;
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
    addr = '0;
    bank_addr = '0;
    dqm = 2'b00;
    dq_in = '0;
    test_reset();
    test_ref();
    test_basic_read();
    test_mask();
    test_burst_wrap();
    test_reset_mid_burst();
    test_alias_preserve();
    test_precharge_ref();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_bram_responder.md
SDRAM_BRAM_RESPONDER -- requirements
Module: sdram_bram_responder

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 12, meaning the row address width.
REQ-002 SHALL have parameter COL_WIDTH, default 8, meaning the column address width.
REQ-003 SHALL have parameter BANK_WIDTH, default 2, meaning the bank address width.
REQ-004 SHALL have parameter SDRADDR_WIDTH, default max(ROW_WIDTH,COL_WIDTH), meaning the SDRAM address bus width.
REQ-005 SHALL have parameter MEM_ADDR_WIDTH, default 10, meaning the backing store depth as log2 of 16-bit words.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port addr, input, SDRADDR_WIDTH bits: SDRAM address bus.
REQ-009 SHALL have port bank_addr, input, BANK_WIDTH bits: bank select.
REQ-010 SHALL have ports clken, cs_n, ras_n, cas_n, we_n, input, 1 bit each: command pins.
REQ-011 SHALL have port dqm, input, 2 bits: write byte masks, [1]=upper byte, [0]=lower byte.
REQ-012 SHALL have port dq_in, input, 16 bits: write data from the controller.
REQ-013 SHALL have port dq_out, output, 16 bits: read data.
REQ-014 SHALL have port dq_oe, output, 1 bit: read data valid / drive enable.
REQ-015 SHALL have port proto_err, output, 1 bit: sticky protocol violation flag.
REQ-016 SHALL have port ref_count, output, 16 bits: count of accepted REF commands, saturating at 0xFFFF.

Function
REQ-017 SHALL decode a command only when clken=1 and cs_n=0; {ras_n,cas_n,we_n}: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS; any other cycle counts as NOP.
REQ-018 SHALL hold a mode register updated by MRS from addr[9:0]: addr[2:0] BL (000=1, 001=2, 010=4, 011=8, other=1); addr[6:4] CL (011=3, else 2); addr[9] write mode (1=single, 0=burst).
REQ-019 SHALL track each bank's state (open or closed) and its open row; ACT opens the addressed bank with row=addr[ROW_WIDTH-1:0].
REQ-020 SHALL close all banks on PRE when addr[10]=1, and only bank_addr when addr[10]=0.
REQ-021 SHALL form the storage index as {bank,row,col} truncated to its low MEM_ADDR_WIDTH bits (aliasing wrap).
REQ-022 SHALL start a READ burst of BL words with column order sequential and wrapped within the BL-aligned block.
REQ-023 SHALL assert dq_oe for exactly BL consecutive cycles, the first word valid CL cycles after the READ command edge.
REQ-024 SHALL, on WRITE, store dq_in at the command edge; later burst words (write mode 0 only) are stored on the following BL-1 edges.
REQ-025 SHALL leave the upper byte unwritten when dqm[1]=1 and the lower byte unwritten when dqm[0]=1; read DQM is ignored.
REQ-026 SHALL close the bank after the last burst word when addr[10]=1 on READ/WRITE (auto-precharge).
REQ-027 SHALL have a new READ/WRITE truncate any burst in progress; the new burst's timing follows REQ-023/REQ-024.
REQ-028 SHALL set proto_err to 1 on any of: ACT to an open bank; READ/WRITE to a closed bank (the command is otherwise ignored, no dq_oe); REF with any bank open.
REQ-029 SHALL hold proto_err high until reset.
REQ-030 SHALL increment ref_count on REF whether or not it was legal.
REQ-031 SHALL drive dq_out to 0 when dq_oe=0.

Reset
REQ-032 SHALL, with rst_n=0 at a posedge, clear dq_oe, dq_out, proto_err and ref_count to 0, close all banks, abort bursts, and set mode to BL=1, CL=2, write mode single.
REQ-033 SHALL preserve storage contents across reset.

Verification
REQ-034 SHALL pass: MRS addr=0x222; ACT bank1 row5; WRITE col 0x10 data 0xA5A5; READ col 0x10 at edge N with addr[10]=1 -> dq_oe=1 on edges N+2..N+5, first word 0xA5A5, bank1 closed afterward, proto_err=0.
REQ-035 SHALL pass: word 0x1234 stored, then WRITE 0xABCD with dqm=2'b10 to the same address -> read returns 0x12CD.
REQ-036 SHALL pass: READ to a closed bank -> proto_err=1 next cycle, dq_oe stays 0.
REQ-037 SHALL pass: MRS addr=0x033 (BL8, CL3); READ col 0x06 -> columns 6,7,0,1,2,3,4,5, first word 3 cycles after the command.
REQ-038 SHALL pass: rst_n low mid-read-burst -> dq_oe=0 at the following edge, ref_count=0, subsequent READ without ACT flags proto_err.
REQ-039 SHALL pass: three REF commands with all banks closed -> ref_count=3, proto_err=0.
